pwm_bank: RTL and testbench

- Parametrised successor to the single-channel fixed-divider square-wave generator.
- Drives CHANNELS independent PWM outputs, each with a run-time programmable period and duty, plus an LED mirror per channel.
- A valid/ready config port loads shadow registers; updates apply glitch-free at period boundaries.
- Sits between the control/sequencer logic and the motor/servo/indicator pins.

---
 rtl/pwm_bank.sv | 127 ++++++++++++
 tb/tb_pwm_bank.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
// pwm_bank: CHANNELS independent PWM generators with run-time period/duty.
// Config writes land in per-channel shadow registers and are copied into the
// active set only at a period boundary (or immediately while a channel is
// idle), so an output never sees a truncated or stretched pulse.
// Optional feature macro: PWM_BANK_POLARITY_EN adds a per-channel output
// invert bit (cfg_invert), shadowed and applied together with period/duty.
module pwm_bank #(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 32,
  parameter int DEF_PERIOD = 80000,
  parameter int DEF_DUTY   = 40000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [3:0]          cfg_ch,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_duty,
`ifdef PWM_BANK_POLARITY_EN
  input  logic                cfg_invert,
`endif
  output logic                cfg_err,
  output logic [CHANNELS-1:0] pwm,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] period_tick
);

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] RST_DUTY   = CNT_W'(DEF_DUTY);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [4:0]       NUM_CH     = 5'(CHANNELS);

  logic wr_en;
  logic ch_ok;

  // The config port can take a write in every cycle except the reset cycle.
  assign cfg_ready = ~rst;
  assign wr_en     = cfg_valid && cfg_ready;
  assign ch_ok     = ({1'b0, cfg_ch} < NUM_CH);
  assign led       = pwm;

  // One-cycle error pulse for a write addressed past the last channel.
  always_ff @(posedge clk) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= wr_en && !ch_ok;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_period;
    logic [CNT_W-1:0] act_duty;
    logic [CNT_W-1:0] shd_period;
    logic [CNT_W-1:0] shd_duty;
    logic             pending;
    logic             pwm_q;
    logic             tick_q;
    logic             run;
    logic             at_end;
    logic             hit;
    logic             act_inv;
`ifdef PWM_BANK_POLARITY_EN
    logic             shd_inv;
`endif

    // A zero period parks the channel exactly like en=0.
    assign run    = en[i] && (act_period != '0);
    assign at_end = (cnt == act_period - ONE);
    assign hit    = wr_en && ch_ok && (cfg_ch == 4'(i));

    assign pwm[i]         = pwm_q;
    assign period_tick[i] = tick_q;

`ifndef PWM_BANK_POLARITY_EN
    assign act_inv = 1'b0;
`endif

    // Per-channel counter, shadow-to-active transfer and registered outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt        <= '0;
        act_period <= RST_PERIOD;
        act_duty   <= RST_DUTY;
        shd_period <= RST_PERIOD;
        shd_duty   <= RST_DUTY;
        pending    <= 1'b0;
        pwm_q      <= 1'b0;
        tick_q     <= 1'b0;
`ifdef PWM_BANK_POLARITY_EN
        act_inv    <= 1'b0;
        shd_inv    <= 1'b0;
`endif
      end else begin
        // Apply the pre-edge shadow at a wrap, or straight away when idle.
        if (pending && (!run || at_end)) begin
          act_period <= shd_period;
          act_duty   <= shd_duty;
`ifdef PWM_BANK_POLARITY_EN
          act_inv    <= shd_inv;
`endif
          pending    <= 1'b0;
        end
        // NOTE: this later non-blocking assignment overrides the pending
        // clear above, so a write coinciding with a wrap stays pending.
        if (hit) begin
          shd_period <= cfg_period;
          shd_duty   <= cfg_duty;
`ifdef PWM_BANK_POLARITY_EN
          shd_inv    <= cfg_invert;
`endif
          pending    <= 1'b1;
        end
        if (run) begin
          cnt    <= at_end ? '0 : cnt + ONE;
          tick_q <= at_end;
          pwm_q  <= (cnt < act_duty) ^ act_inv;
        end else begin
          cnt    <= '0;
          tick_q <= 1'b0;
          pwm_q  <= act_inv;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: directed scenarios followed by random
// traffic, every cycle compared against a behavioural per-channel model.
module tb_pwm_bank;
  localparam int CHANNELS   = 4;
  localparam int CNT_W      = 16;
  localparam int DEF_PERIOD = 20;
  localparam int DEF_DUTY   = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic [CHANNELS-1:0] en;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [3:0]          cfg_ch;
  logic [CNT_W-1:0]    cfg_period;
  logic [CNT_W-1:0]    cfg_duty;
  logic                cfg_err;
  logic [CHANNELS-1:0] pwm;
  logic [CHANNELS-1:0] led;
  logic [CHANNELS-1:0] period_tick;

  pwm_bank #(
    .CHANNELS(CHANNELS), .CNT_W(CNT_W),
    .DEF_PERIOD(DEF_PERIOD), .DEF_DUTY(DEF_DUTY)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty),
`ifdef PWM_BANK_POLARITY_EN
    .cfg_invert(1'b0),
`endif
    .cfg_err(cfg_err), .pwm(pwm), .led(led), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each channel is a position within its current period;
  // output high while position < duty, tick on the last position.
  int unsigned m_period [CHANNELS];
  int unsigned m_duty   [CHANNELS];
  int unsigned m_speriod[CHANNELS];
  int unsigned m_sduty  [CHANNELS];
  int unsigned m_pos    [CHANNELS];
  bit          m_pend   [CHANNELS];
  bit [CHANNELS-1:0] m_pwm;
  bit [CHANNELS-1:0] m_tick;
  bit                m_err;

  task automatic model_edge();
    if (rst === 1'b1) begin
      for (int i = 0; i < CHANNELS; i++) begin
        m_period[i] = DEF_PERIOD; m_duty[i] = DEF_DUTY;
        m_speriod[i] = DEF_PERIOD; m_sduty[i] = DEF_DUTY;
        m_pos[i] = 0; m_pend[i] = 0;
      end
      m_pwm = '0; m_tick = '0; m_err = 0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        bit live, last;
        live = (en[i] === 1'b1) && (m_period[i] != 0);
        last = live && (m_pos[i] == m_period[i] - 1);
        m_pwm[i]  = live && (m_pos[i] < m_duty[i]);
        m_tick[i] = last;
        m_pos[i]  = live ? (m_pos[i] + 1) % m_period[i] : 0;
        if (m_pend[i] && (!live || last)) begin
          m_period[i] = m_speriod[i];
          m_duty[i]   = m_sduty[i];
          m_pend[i]   = 0;
        end
      end
      m_err = 0;
      if (cfg_valid === 1'b1) begin
        if (int'(cfg_ch) < CHANNELS) begin
          m_speriod[cfg_ch] = cfg_period;
          m_sduty[cfg_ch]   = cfg_duty;
          m_pend[cfg_ch]    = 1;
        end else begin
          m_err = 1;
        end
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, " pwm"},   32'(pwm),         32'(m_pwm));
    check({tag, " led"},   32'(led),         32'(m_pwm));
    check({tag, " tick"},  32'(period_tick), 32'(m_tick));
    check({tag, " err"},   32'(cfg_err),     32'(m_err));
    check({tag, " ready"}, 32'(cfg_ready),   32'(!rst));
    cfg_valid = 1'b0;
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic write(input int ch, input int p, input int d, input string tag);
    cfg_valid  = 1'b1;
    cfg_ch     = 4'(ch);
    cfg_period = CNT_W'(p);
    cfg_duty   = CNT_W'(d);
    step(tag);
  endtask

  initial begin
    int guard;
    rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0;
    cfg_period = '0; cfg_duty = '0;

    run(2, "reset");
    rst = 1'b0;
    // Defaults on channel 0.
    en[0] = 1'b1;
    run(45, "defaults");

    // Channel 1 programmed while idle, then enabled: pattern 1,0,0,0.
    write(1, 4, 1, "ch1_cfg");
    step("ch1_idle");
    en[1] = 1'b1;
    step("ch1_first");
    check("ch1 first high", 32'(pwm[1]), 32'd1);
    run(12, "ch1_run");

    // Channel 2 at 10/5, reprogrammed mid-period to 6/3.
    write(2, 10, 5, "ch2_cfg");
    en[2] = 1'b1;
    run(4, "ch2_run");
    write(2, 6, 3, "ch2_mid");
    run(24, "ch2_new");

    // Write A mid-period, then write B exactly on the wrap cycle.
    write(2, 8, 2, "ch2_A");
    guard = 0;
    while (m_pos[2] != m_period[2] - 1 && guard < 50) begin
      step("ch2_wait");
      guard++;
    end
    check("ch2 wrap wait", 32'(guard < 50), 32'd1);
    write(2, 5, 4, "ch2_B_on_wrap");
    check("ch2 A active at wrap", m_period[2], 32'd8);
    run(20, "ch2_after");

    // Out-of-range channel, then duty boundary cases on channel 3.
    write(15, 3, 1, "bad_ch");
    step("bad_ch_pulse");
    write(3, 7, 0, "ch3_d0");
    en[3] = 1'b1;
    run(16, "ch3_zero");
    write(3, 7, 7, "ch3_full");
    run(16, "ch3_full");
    write(3, 1, 1, "ch3_p1");
    run(6, "ch3_p1");
    write(3, 0, 1, "ch3_p0");
    run(6, "ch3_p0");

    // Reset mid-period with a pending write.
    write(0, 3, 2, "pend_before_rst");
    rst = 1'b1;
    step("mid_rst");
    rst = 1'b0;
    run(25, "post_rst");

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) en[$urandom_range(0, CHANNELS-1)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0) begin
        cfg_valid  = 1'b1;
        cfg_ch     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15))
                                                 : 4'($urandom_range(0, CHANNELS-1));
        cfg_period = CNT_W'($urandom_range(0, 12));
        cfg_duty   = CNT_W'($urandom_range(0, 14));
      end
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
